// File: rtl/posit_bfly_feeder_pkg.sv
// Shared types and constants for the posit32 butterfly feeder.
package posit_bfly_feeder_pkg;

    typedef enum logic [2:0] {
        LOAD_A   = 3'd0,
        LOAD_B   = 3'd1,
        WAIT_ADD = 3'd2,
        OUT_ADD  = 3'd3,
        WAIT_SUB = 3'd4,
        OUT_SUB  = 3'd5
    } bfly_state_e;

    // posit32 Not-a-Real pattern, emitted when the adder never answers
    localparam logic [31:0] POSIT_NAR = 32'h8000_0000;

    // complex adder operation select
    localparam logic ADD_OP_SUM  = 1'b0;
    localparam logic ADD_OP_DIFF = 1'b1;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
    } cplx_t;

endpackage

// File: rtl/posit_bfly_feeder.sv
// Butterfly feeder: collects a sample pair (A, B), drives an external complex
// posit adder for A+B then A-B, and presents both results in order.
// Optional adder-done watchdog: define POSIT_BFLY_TIMEOUT_EN.
module posit_bfly_feeder
    import posit_bfly_feeder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_re,
    input  logic [31:0] in_im,
    output logic        add_start,
    output logic [31:0] a_re,
    output logic [31:0] a_im,
    output logic [31:0] b_re,
    output logic [31:0] b_im,
    output logic        add_op,
    input  logic        add_done,
    input  logic [31:0] add_re,
    input  logic [31:0] add_im,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_re,
    output logic [31:0] out_im,
    output logic        out_sel,
    output logic        err
);

    bfly_state_e state_q, state_d;
    logic        live_q;     // low until the first clock after reset, keeps in_ready low in reset
    cplx_t       a_q, b_q, res_q;
    logic        sel_q;
    logic        in_fire;
    logic        res_take;
    logic        res_nar;
    logic        wd_expired;
    logic        in_wait;

    assign in_wait = (state_q == WAIT_ADD) || (state_q == WAIT_SUB);
    assign in_fire = in_valid && in_ready;

`ifdef POSIT_BFLY_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wd_cnt_q;
    logic          err_q;

    assign wd_expired = in_wait && (wd_cnt_q == CW'(TIMEOUT_CYCLES));
    assign err        = err_q;

    // watchdog counts cycles spent in a WAIT state, restarting on every state change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_cnt_q <= '0;
        else if (!in_wait || (state_d != state_q))
            wd_cnt_q <= '0;
        else
            wd_cnt_q <= wd_cnt_q + 1'b1;
    end

    // sticky error once any result had to be substituted with NaR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (res_take && res_nar)
            err_q <= 1'b1;
    end
`else
    assign wd_expired = 1'b0;
    assign err        = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
        end
    end

    // next-state and handshake outputs
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        add_start = 1'b0;
        add_op    = ADD_OP_SUM;
        out_valid = 1'b0;
        res_take  = 1'b0;
        res_nar   = 1'b0;
        case (state_q)
            LOAD_A: begin
                in_ready = live_q;
                if (in_valid && live_q) state_d = LOAD_B;
            end
            LOAD_B: begin
                in_ready = live_q;
                if (in_valid && live_q) state_d = WAIT_ADD;
            end
            WAIT_ADD: begin
                add_start = 1'b1;
                if (add_done || wd_expired) begin
                    res_take = 1'b1;
                    res_nar  = !add_done;
                    state_d  = OUT_ADD;
                end
            end
            OUT_ADD: begin
                out_valid = 1'b1;
                if (out_ready) state_d = WAIT_SUB;
            end
            WAIT_SUB: begin
                add_start = 1'b1;
                add_op    = ADD_OP_DIFF;
                if (add_done || wd_expired) begin
                    res_take = 1'b1;
                    res_nar  = !add_done;
                    state_d  = OUT_SUB;
                end
            end
            OUT_SUB: begin
                out_valid = 1'b1;
                add_op    = ADD_OP_DIFF;
                if (out_ready) state_d = LOAD_A;
            end
            default: state_d = LOAD_A;
        endcase
    end

    // operand capture and result register; operands hold until the next A arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            sel_q <= ADD_OP_SUM;
        end else begin
            if (in_fire && (state_q == LOAD_A)) a_q <= {in_re, in_im};
            if (in_fire && (state_q == LOAD_B)) b_q <= {in_re, in_im};
            if (res_take) begin
                res_q <= res_nar ? {POSIT_NAR, POSIT_NAR} : {add_re, add_im};
                sel_q <= (state_q == WAIT_SUB) ? ADD_OP_DIFF : ADD_OP_SUM;
            end
        end
    end

    assign a_re    = a_q.re;
    assign a_im    = a_q.im;
    assign b_re    = b_q.re;
    assign b_im    = b_q.im;
    assign out_re  = res_q.re;
    assign out_im  = res_q.im;
    assign out_sel = sel_q;

endmodule

// File: tb/tb_posit_bfly_feeder.sv
// Directed bench for posit_bfly_feeder with a behavioural complex-adder stub.
// Define POSIT_BFLY_TIMEOUT_EN to also exercise the watchdog path.
module tb_posit_bfly_feeder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_re, in_im;
    logic        add_start, add_op, add_done;
    logic [31:0] a_re, a_im, b_re, b_im, add_re, add_im;
    logic        out_valid, out_ready, out_sel, err;
    logic [31:0] out_re, out_im;

    int n_cmp = 0;
    int n_err = 0;
    int dly = 0;          // adder latency in add_start cycles; -1 = never answers
    int st_cnt = 0;
    logic force_done = 1'b0;

    logic [31:0] sre [4] = '{32'h10, 32'h3, 32'h100, 32'h1};
    logic [31:0] sim [4] = '{32'h20, 32'h5, 32'h40, 32'h2};
    logic [31:0] ere [4] = '{32'h13, 32'hD, 32'h101, 32'hFF};
    logic [31:0] eim [4] = '{32'h25, 32'h1B, 32'h42, 32'h3E};
    logic [31:0] esel[4] = '{32'd0, 32'd1, 32'd0, 32'd1};

    posit_bfly_feeder #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .add_start(add_start), .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .add_op(add_op), .add_done(add_done), .add_re(add_re), .add_im(add_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_sel(out_sel), .err(err)
    );

    always #5 clk = ~clk;

    // stub adder: exact posit results for the unit-value vectors, plain integer math otherwise
    function automatic logic [31:0] stub_add(input logic [31:0] x, input logic [31:0] y, input logic op);
        if (!op && x == 32'h4000_0000 && y == 32'h4000_0000) return 32'h4800_0000;
        if (!op && x == 32'h4800_0000 && y == 32'h4000_0000) return 32'h4C00_0000;
        if ( op && x == 32'h4800_0000 && y == 32'h4000_0000) return 32'h4000_0000;
        if ( op && x == y) return 32'h0;
        return op ? x - y : x + y;
    endfunction

    assign add_re   = force_done ? 32'hBAD0_0000 : stub_add(a_re, b_re, add_op);
    assign add_im   = force_done ? 32'hBAD0_0001 : stub_add(a_im, b_im, add_op);
    assign add_done = force_done || (add_start && dly >= 0 && st_cnt == dly);

    // adder latency counter: cycles add_start has been waiting
    always @(posedge clk) st_cnt <= (add_start && !add_done) ? st_cnt + 1 : 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] re, input logic [31:0] im);
        logic got;
        got = 1'b0;
        in_valid = 1'b1; in_re = re; in_im = im;
        for (int k = 0; k < 40 && !got; k++) begin
            got = in_ready;
            tick();
        end
        in_valid = 1'b0;
        chk("send_accepted", {31'b0, got}, 32'd1);
    endtask

    task automatic get(input string tag, input logic [31:0] ere_i, input logic [31:0] eim_i, input logic esel_i);
        out_ready = 1'b1;
        for (int k = 0; k < 40 && !out_valid; k++) tick();
        chk({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_re"}, out_re, ere_i);
        chk({tag, "_im"}, out_im, eim_i);
        chk({tag, "_sel"}, {31'b0, out_sel}, {31'b0, esel_i});
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int waited, idx, nres;
        logic took;
        rst_n = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b0;
        #1;
        // reset state
        chk("rst_in_ready", {31'b0, in_ready}, 0);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_add_start", {31'b0, add_start}, 0);
        chk("rst_add_op", {31'b0, add_op}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_out_re", out_re, 0);
        chk("rst_a_re", a_re, 0);
        chk("rst_b_im", b_im, 0);
        chk("rst_out_sel", {31'b0, out_sel}, 0);
        repeat (2) tick();
        chk("rst_hold_rdy", {31'b0, in_ready}, 0);
        rst_n = 1'b1;
        tick();
        chk("rel_in_ready", {31'b0, in_ready}, 1);

        // unit-value butterfly and cycle latency
        send(32'h4000_0000, 32'h4800_0000);
        send(32'h4000_0000, 32'h4000_0000);
        out_ready = 1'b1;
        chk("t1_add_start", {31'b0, add_start}, 1);
        chk("t1_add_op", {31'b0, add_op}, 0);
        chk("t1_in_ready", {31'b0, in_ready}, 0);
        chk("t1_a_im", a_im, 32'h4800_0000);
        chk("t1_b_re", b_re, 32'h4000_0000);
        tick();
        chk("t1_sum_vld", {31'b0, out_valid}, 1);
        chk("t1_sum_re", out_re, 32'h4800_0000);
        chk("t1_sum_im", out_im, 32'h4C00_0000);
        chk("t1_sum_sel", {31'b0, out_sel}, 0);
        tick();
        chk("t1_wsub_start", {31'b0, add_start}, 1);
        chk("t1_wsub_op", {31'b0, add_op}, 1);
        chk("t1_wsub_vld", {31'b0, out_valid}, 0);
        tick();
        chk("t1_dif_vld", {31'b0, out_valid}, 1);
        chk("t1_dif_re", out_re, 32'h0);
        chk("t1_dif_im", out_im, 32'h4000_0000);
        chk("t1_dif_sel", {31'b0, out_sel}, 1);
        tick();
        out_ready = 1'b0;
        chk("t1_back_rdy", {31'b0, in_ready}, 1);

        // output stall with spurious add_done and a waiting upstream sample
        send(32'h100, 32'h200);
        send(32'h10, 32'h20);
        tick();
        force_done = 1'b1;
        in_valid = 1'b1; in_re = 32'h5555; in_im = 32'h6666;
        for (int c = 0; c < 10; c++) begin
            chk("stall_vld", {31'b0, out_valid}, 1);
            chk("stall_re", out_re, 32'h110);
            chk("stall_im", out_im, 32'h220);
            chk("stall_start", {31'b0, add_start}, 0);
            chk("stall_rdy", {31'b0, in_ready}, 0);
            tick();
        end
        force_done = 1'b0;
        in_valid = 1'b0;
        get("stall_sum", 32'h110, 32'h220, 1'b0);
        get("stall_dif", 32'hF0, 32'h1E0, 1'b1);

        // continuous in_valid over four samples
        out_ready = 1'b1;
        idx = 0; nres = 0;
        for (int c = 0; c < 60 && nres < 4; c++) begin
            if (idx < 4) begin
                in_valid = 1'b1; in_re = sre[idx]; in_im = sim[idx];
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                chk("pair_re", out_re, ere[nres]);
                chk("pair_im", out_im, eim[nres]);
                chk("pair_sel", {31'b0, out_sel}, esel[nres]);
                nres++;
            end
            if (out_valid || add_start) chk("pair_rdy_low", {31'b0, in_ready}, 0);
            took = in_valid && in_ready;
            tick();
            if (took) idx++;
        end
        in_valid = 1'b0;
        chk("pair_nres", nres, 4);
        chk("pair_nin", idx, 4);
        for (int c = 0; c < 8; c++) begin
            chk("pair_no_extra", {31'b0, out_valid}, 0);
            tick();
        end
        out_ready = 1'b0;

        // slow adder: operands and add_start hold for the whole wait
        dly = 5;
        send(32'h1000, 32'h2000);
        send(32'h0100, 32'h0200);
        out_ready = 1'b1;
        waited = 0;
        while (!out_valid && waited < 20) begin
            chk("slow_start", {31'b0, add_start}, 1);
            chk("slow_a_re", a_re, 32'h1000);
            chk("slow_a_im", a_im, 32'h2000);
            chk("slow_b_re", b_re, 32'h0100);
            chk("slow_b_im", b_im, 32'h0200);
            waited++;
            tick();
        end
        chk("slow_wait", waited, 6);
        chk("slow_sum_re", out_re, 32'h1100);
        chk("slow_sum_im", out_im, 32'h2200);
        tick();
        chk("slow_once", {31'b0, out_valid}, 0);
        get("slow_dif", 32'h0F00, 32'h1E00, 1'b1);
        dly = 0;

        // reset while waiting for the difference
        send(32'h4000_0000, 32'h4000_0000);
        send(32'h1, 32'h1);
        out_ready = 1'b1;
        tick();
        dly = -1;
        tick();
        tick();
        chk("mid_wsub_op", {31'b0, add_op}, 1);
        chk("mid_wsub_start", {31'b0, add_start}, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", {31'b0, out_valid}, 0);
        chk("mid_rst_start", {31'b0, add_start}, 0);
        chk("mid_rst_rdy", {31'b0, in_ready}, 0);
        chk("mid_rst_a", a_re, 0);
        chk("mid_rst_out", out_re, 0);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b0;
        dly = 0;
        tick();
        chk("mid_rel_rdy", {31'b0, in_ready}, 1);
        send(32'h7, 32'h9);
        send(32'h2, 32'h3);
        get("mid_sum", 32'h9, 32'hC, 1'b0);
        get("mid_dif", 32'h5, 32'h6, 1'b1);

`ifdef POSIT_BFLY_TIMEOUT_EN
        // adder never answers: watchdog substitutes NaR
        dly = -1;
        send(32'h11, 32'h22);
        send(32'h33, 32'h44);
        out_ready = 1'b1;
        for (int k = 0; k < 30 && !out_valid; k++) tick();
        chk("wd_vld", {31'b0, out_valid}, 1);
        chk("wd_err", {31'b0, err}, 1);
        chk("wd_sum_re", out_re, 32'h8000_0000);
        chk("wd_sum_im", out_im, 32'h8000_0000);
        tick();
        get("wd_dif", 32'h8000_0000, 32'h8000_0000, 1'b1);
        chk("wd_err_sticky", {31'b0, err}, 1);
        chk("wd_back_rdy", {31'b0, in_ready}, 1);
        dly = 0;
`else
        chk("no_wd_err", {31'b0, err}, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
